// File: rtl/div_ctrl_pkg.sv
// rtl/div_ctrl_pkg.sv - shared state encoding and sizing for the divide controller
package div_ctrl_pkg;

  localparam int CNT_W              = 7;
  localparam int DEF_TIMEOUT_CYCLES = 64;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

endpackage

// File: rtl/div_watchdog.sv
// rtl/div_watchdog.sv - cycle counter that flags a divide running too long
module div_watchdog
  import div_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + 1'b1;
    end
  end

  assign expired = enable && (count == CNT_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/div_ctrl.sv
// rtl/div_ctrl.sv - DIV/DIVU sequencer owning HI/LO; DIV_ZERO_FAST_EN enables the zero-divisor bypass
module div_ctrl
  import div_ctrl_pkg::*;
#(
  parameter int          TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter logic [31:0] HILO_RESET     = 32'd0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        issue_valid,
  input  logic        issue_signed,
  input  logic [31:0] issue_op1,
  input  logic [31:0] issue_op2,
  output logic        issue_ready,
  input  logic        flush,
  input  logic        mthi_we,
  input  logic        mtlo_we,
  input  logic [31:0] mt_data,
  output logic        div_begin,
  output logic        div_sign,
  output logic [31:0] div_op1,
  output logic [31:0] div_op2,
  input  logic [31:0] div_result,
  input  logic [31:0] div_remainder,
  input  logic        div_end,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output logic        div_err
);

  state_t state, state_nxt;
  logic   accept, fast_zero, capture, timeout, wd_expired;
  logic   drop_hi, drop_lo;

  div_watchdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_watchdog (
    .clk    (clk),
    .reset  (reset),
    .clear  (accept),
    .enable (state == ST_RUN),
    .expired(wd_expired)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    fast_zero = 1'b0;
    capture   = 1'b0;
    timeout   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (issue_valid && !flush) begin
          accept = 1'b1;
`ifdef DIV_ZERO_FAST_EN
          fast_zero = (issue_op2 == 32'd0);
`endif
          state_nxt = fast_zero ? ST_DRAIN : ST_RUN;
        end
      end
      ST_RUN: begin
        // flush outranks a completing divide so cancelled results never land
        if (flush) begin
          state_nxt = ST_DRAIN;
        end else if (div_end) begin
          capture   = 1'b1;
          state_nxt = ST_DRAIN;
        end else if (wd_expired) begin
          timeout   = 1'b1;
          state_nxt = ST_DRAIN;
        end
      end
      ST_DRAIN: state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      div_begin <= 1'b0;
      div_sign  <= 1'b0;
      div_op1   <= 32'd0;
      div_op2   <= 32'd0;
      hi        <= HILO_RESET;
      lo        <= HILO_RESET;
      div_err   <= 1'b0;
      drop_hi   <= 1'b0;
      drop_lo   <= 1'b0;
    end else begin
      div_err <= timeout;
      if (accept) begin
        div_op1   <= issue_op1;
        div_op2   <= issue_op2;
        div_sign  <= issue_signed;
        div_begin <= !fast_zero;
        drop_hi   <= 1'b0;
        drop_lo   <= 1'b0;
      end else if (state == ST_RUN) begin
        if (state_nxt != ST_RUN) div_begin <= 1'b0;
        // a newer MTHI/MTLO must survive the eventual divide result
        if (mthi_we) drop_hi <= 1'b1;
        if (mtlo_we) drop_lo <= 1'b1;
      end
      if (mthi_we)                  hi <= mt_data;
      else if (capture && !drop_hi) hi <= div_remainder;
      else if (fast_zero)           hi <= issue_op1;
      if (mtlo_we)                  lo <= mt_data;
      else if (capture && !drop_lo) lo <= div_result;
      else if (fast_zero)           lo <= 32'hFFFF_FFFF;
    end
  end

  assign issue_ready = (state == ST_IDLE);
  assign busy        = (state != ST_IDLE);

endmodule
